// File: rtl/duck_bus_responder_if.sv
// CPU-side memory bus between the core and the bus responder.
// The CPU drives requests (master). The responder returns wait and read data (slave).
interface duck_bus_if;
  logic [15:0] bus_address_in;
  logic [7:0]  bus_data_in;
  logic [7:0]  bus_data_out;
  logic        bus_read;
  logic        bus_write;
  logic        bus_wait;

  modport slave (
    input  bus_address_in, bus_data_in, bus_read, bus_write,
    output bus_data_out, bus_wait
  );

  modport master (
    output bus_address_in, bus_data_in, bus_read, bus_write,
    input  bus_data_out, bus_wait
  );
endinterface

// File: rtl/duck_bus_responder.sv
// Services CPU bus requests as a multiplexed address/data cycle on the external AD pins
// (address high, address low, then the access). The CPU is stalled until the cycle completes.
module duck_bus_responder #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  duck_bus_if.slave   bus,
  input  logic [7:0]  ext_ad_in,
  output logic [7:0]  ext_ad_out,
  output logic [7:0]  ext_ad_oe,
  output logic        ext_ale_hi,
  output logic        ext_ale_lo,
  output logic        ext_rd_n,
  output logic        ext_wr_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_ACCESS, S_DONE
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_addr_lo, r_wdata, r_data_out;
  logic       r_is_rd;
  logic [7:0] r_ad_out, w_ad_nxt;
  logic       r_oe, w_oe_nxt;
  logic       r_ale_hi, w_ale_hi_nxt;
  logic       r_ale_lo, w_ale_lo_nxt;
  logic       r_rd_n, w_rd_n_nxt;
  logic       r_wr_n, w_wr_n_nxt;
  logic       w_req, w_latch, w_cap;

  assign w_req = bus.bus_read | bus.bus_write;

  // Pin outputs are registered, so each one is computed for the state being entered.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_ad_nxt     = 8'h00;
    w_oe_nxt     = 1'b0;
    w_ale_hi_nxt = 1'b0;
    w_ale_lo_nxt = 1'b0;
    w_rd_n_nxt   = 1'b1;
    w_wr_n_nxt   = 1'b1;
    w_latch      = 1'b0;
    w_cap        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_nxt  = S_ADDR_HI;
          w_latch      = 1'b1;
          w_ad_nxt     = bus.bus_address_in[15:8];
          w_oe_nxt     = 1'b1;
          w_ale_hi_nxt = 1'b1;
        end
      end
      S_ADDR_HI: begin
        w_state_nxt  = S_ADDR_LO;
        w_ad_nxt     = r_addr_lo;
        w_oe_nxt     = 1'b1;
        w_ale_lo_nxt = 1'b1;
      end
      S_ADDR_LO, S_ACCESS: begin
        if (r_state == S_ACCESS && r_cnt == 4'd0) begin
          w_state_nxt = S_DONE;
          w_cap       = r_is_rd;
        end else begin
          w_state_nxt = S_ACCESS;
          w_cnt_nxt   = (r_state == S_ADDR_LO) ? WAIT_LD : r_cnt - 4'd1;
          if (r_is_rd) begin
            w_rd_n_nxt = 1'b0;
          end else begin
            w_ad_nxt   = r_wdata;
            w_oe_nxt   = 1'b1;
            w_wr_n_nxt = 1'b0;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_addr_lo  <= 8'h00;
      r_wdata    <= 8'h00;
      r_is_rd    <= 1'b0;
      r_data_out <= 8'h00;
      r_ad_out   <= 8'h00;
      r_oe       <= 1'b0;
      r_ale_hi   <= 1'b0;
      r_ale_lo   <= 1'b0;
      r_rd_n     <= 1'b1;
      r_wr_n     <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ad_out <= w_ad_nxt;
      r_oe     <= w_oe_nxt;
      r_ale_hi <= w_ale_hi_nxt;
      r_ale_lo <= w_ale_lo_nxt;
      r_rd_n   <= w_rd_n_nxt;
      r_wr_n   <= w_wr_n_nxt;
      // A read wins when both requests are raised together.
      if (w_latch) begin
        r_addr_lo <= bus.bus_address_in[7:0];
        r_wdata   <= bus.bus_data_in;
        r_is_rd   <= bus.bus_read;
      end
      if (w_cap) r_data_out <= ext_ad_in;
    end
  end

  assign bus.bus_wait     = w_req & (r_state != S_DONE);
  assign bus.bus_data_out = r_data_out;
  assign ext_ad_out       = r_ad_out;
  assign ext_ad_oe        = {8{r_oe}};
  assign ext_ale_hi       = r_ale_hi;
  assign ext_ale_lo       = r_ale_lo;
  assign ext_rd_n         = r_rd_n;
  assign ext_wr_n         = r_wr_n;

endmodule

// File: tb/tb_duck_bus_responder.sv
// Directed bench for duck_bus_responder with WAIT_CYCLES=1 (ACCESS lasts two clocks).
// Each cycle's pins are packed as {wait, ale_hi, ale_lo, rd_n, wr_n, oe, ad}.
module tb_duck_bus_responder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ext_ad_in, ext_ad_out, ext_ad_oe;
  logic       ext_ale_hi, ext_ale_lo, ext_rd_n, ext_wr_n;
  int         n_vec = 0;
  int         n_err = 0;

  duck_bus_if bif ();

  duck_bus_responder #(.WAIT_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif.slave),
    .ext_ad_in(ext_ad_in), .ext_ad_out(ext_ad_out), .ext_ad_oe(ext_ad_oe),
    .ext_ale_hi(ext_ale_hi), .ext_ale_lo(ext_ale_lo),
    .ext_rd_n(ext_rd_n), .ext_wr_n(ext_wr_n)
  );

  always #5 clk = ~clk;

  wire [20:0] obs = {bif.bus_wait, ext_ale_hi, ext_ale_lo, ext_rd_n, ext_wr_n, ext_ad_oe, ext_ad_out};

  function automatic logic [20:0] E(logic w, logic ah, logic al, logic rn, logic wn,
                                    logic [7:0] oe, logic [7:0] ad);
    return {w, ah, al, rn, wn, oe, ad};
  endfunction

  // When the pins are not driven, the AD value is a don't-care.
  function automatic logic [20:0] M(logic [20:0] e);
    return (e[15:8] == 8'hFF) ? 21'h1FFFFF : 21'h1FFF00;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; bif.bus_read = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (obs !== E(1, 0, 0, 1, 1, 8'h00, 8'h00)) begin
      n_err++; $display("FAIL reset_pins got %h exp %h", obs, E(1, 0, 0, 1, 1, 8'h00, 8'h00));
    end
    n_vec++;
    if (bif.bus_data_out !== 8'h00) begin
      n_err++; $display("FAIL reset_data got %h exp 00", bif.bus_data_out);
    end
    bif.bus_read = 1'b0;
    #1;
    n_vec++;
    if (bif.bus_wait !== 1'b0) begin
      n_err++; $display("FAIL reset_wait_drop got %b exp 0", bif.bus_wait);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (obs !== E(0, 0, 0, 1, 1, 8'h00, 8'h00)) begin
      n_err++; $display("FAIL reset_idle got %h exp %h", obs, E(0, 0, 0, 1, 1, 8'h00, 8'h00));
    end
  endtask

  task automatic test_read();
    logic [20:0] exp [1:5];
    exp[1] = E(1, 1, 0, 1, 1, 8'hFF, 8'h12);
    exp[2] = E(1, 0, 1, 1, 1, 8'hFF, 8'hA4);
    exp[3] = E(1, 0, 0, 0, 1, 8'h00, 8'h00);
    exp[4] = E(1, 0, 0, 0, 1, 8'h00, 8'h00);
    exp[5] = E(0, 0, 0, 1, 1, 8'h00, 8'h00);
    @(posedge clk); #1;
    ext_ad_in = 8'h5A; bif.bus_address_in = 16'h12A4; bif.bus_read = 1'b1;
    #1;
    n_vec++;
    if (bif.bus_wait !== 1'b1) begin
      n_err++; $display("FAIL read_c0_wait got %b exp 1", bif.bus_wait);
    end
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      n_vec++;
      if ((obs & M(exp[c])) !== (exp[c] & M(exp[c]))) begin
        n_err++; $display("FAIL read_c%0d got %h exp %h", c, obs, exp[c]);
      end
    end
    n_vec++;
    if (bif.bus_data_out !== 8'h5A) begin
      n_err++; $display("FAIL read_data got %h exp 5a", bif.bus_data_out);
    end
    bif.bus_read = 1'b0;
  endtask

  task automatic test_write();
    logic [20:0] exp [1:5];
    exp[1] = E(1, 1, 0, 1, 1, 8'hFF, 8'hBE);
    exp[2] = E(1, 0, 1, 1, 1, 8'hFF, 8'hEF);
    exp[3] = E(1, 0, 0, 1, 0, 8'hFF, 8'hC3);
    exp[4] = E(1, 0, 0, 1, 0, 8'hFF, 8'hC3);
    exp[5] = E(0, 0, 0, 1, 1, 8'h00, 8'h00);
    @(posedge clk); #1;
    ext_ad_in = 8'h11; bif.bus_address_in = 16'hBEEF; bif.bus_data_in = 8'hC3; bif.bus_write = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      if (c == 2) begin bif.bus_address_in = 16'h0000; bif.bus_data_in = 8'h00; end
      n_vec++;
      if ((obs & M(exp[c])) !== (exp[c] & M(exp[c]))) begin
        n_err++; $display("FAIL write_c%0d got %h exp %h", c, obs, exp[c]);
      end
    end
    n_vec++;
    if (bif.bus_data_out !== 8'h5A) begin
      n_err++; $display("FAIL write_keeps_data got %h exp 5a", bif.bus_data_out);
    end
    bif.bus_write = 1'b0;
  endtask

  task automatic test_both();
    logic [20:0] exp [1:5];
    exp[1] = E(1, 1, 0, 1, 1, 8'hFF, 8'h00);
    exp[2] = E(1, 0, 1, 1, 1, 8'hFF, 8'h01);
    exp[3] = E(1, 0, 0, 0, 1, 8'h00, 8'h00);
    exp[4] = E(1, 0, 0, 0, 1, 8'h00, 8'h00);
    exp[5] = E(0, 0, 0, 1, 1, 8'h00, 8'h00);
    @(posedge clk); #1;
    ext_ad_in = 8'h3C; bif.bus_address_in = 16'h0001; bif.bus_data_in = 8'h55;
    bif.bus_read = 1'b1; bif.bus_write = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      n_vec++;
      if ((obs & M(exp[c])) !== (exp[c] & M(exp[c]))) begin
        n_err++; $display("FAIL both_c%0d got %h exp %h", c, obs, exp[c]);
      end
    end
    n_vec++;
    if (bif.bus_data_out !== 8'h3C) begin
      n_err++; $display("FAIL both_data got %h exp 3c", bif.bus_data_out);
    end
    bif.bus_read = 1'b0; bif.bus_write = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [20:0] exp [1:11];
    exp[1]  = E(1, 1, 0, 1, 1, 8'hFF, 8'h00);
    exp[2]  = E(1, 0, 1, 1, 1, 8'hFF, 8'h10);
    exp[3]  = E(1, 0, 0, 0, 1, 8'h00, 8'h00);
    exp[4]  = E(1, 0, 0, 0, 1, 8'h00, 8'h00);
    exp[5]  = E(0, 0, 0, 1, 1, 8'h00, 8'h00);
    exp[6]  = E(1, 0, 0, 1, 1, 8'h00, 8'h00);
    exp[7]  = E(1, 1, 0, 1, 1, 8'hFF, 8'h00);
    exp[8]  = E(1, 0, 1, 1, 1, 8'hFF, 8'h11);
    exp[9]  = E(1, 0, 0, 1, 0, 8'hFF, 8'h77);
    exp[10] = E(1, 0, 0, 1, 0, 8'hFF, 8'h77);
    exp[11] = E(0, 0, 0, 1, 1, 8'h00, 8'h00);
    @(posedge clk); #1;
    ext_ad_in = 8'h99; bif.bus_address_in = 16'h0010; bif.bus_read = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      n_vec++;
      if ((obs & M(exp[c])) !== (exp[c] & M(exp[c]))) begin
        n_err++; $display("FAIL b2b_c%0d got %h exp %h", c, obs, exp[c]);
      end
      if (c == 5) begin
        bif.bus_read = 1'b0; bif.bus_write = 1'b1;
        bif.bus_address_in = 16'h0011; bif.bus_data_in = 8'h77; ext_ad_in = 8'h00;
      end
    end
    n_vec++;
    if (bif.bus_data_out !== 8'h99) begin
      n_err++; $display("FAIL b2b_data got %h exp 99", bif.bus_data_out);
    end
    bif.bus_write = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bif.bus_address_in = 16'h4000; bif.bus_data_in = 8'hAA; bif.bus_write = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (obs !== E(1, 0, 0, 1, 0, 8'hFF, 8'hAA)) begin
      n_err++; $display("FAIL rmid_access got %h exp %h", obs, E(1, 0, 0, 1, 0, 8'hFF, 8'hAA));
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs !== E(1, 0, 0, 1, 1, 8'h00, 8'h00)) begin
      n_err++; $display("FAIL rmid_async got %h exp %h", obs, E(1, 0, 0, 1, 1, 8'h00, 8'h00));
    end
    bif.bus_write = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (obs !== E(0, 0, 0, 1, 1, 8'h00, 8'h00)) begin
      n_err++; $display("FAIL rmid_idle got %h exp %h", obs, E(0, 0, 0, 1, 1, 8'h00, 8'h00));
    end
    ext_ad_in = 8'h42; bif.bus_address_in = 16'h8001; bif.bus_read = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (obs !== E(1, 1, 0, 1, 1, 8'hFF, 8'h80)) begin
      n_err++; $display("FAIL rmid_restart got %h exp %h", obs, E(1, 1, 0, 1, 1, 8'hFF, 8'h80));
    end
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (bif.bus_wait !== 1'b0 || bif.bus_data_out !== 8'h42) begin
      n_err++; $display("FAIL rmid_read got wait=%b data=%h exp wait=0 data=42", bif.bus_wait, bif.bus_data_out);
    end
    bif.bus_read = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ext_ad_in = 8'h00;
    bif.bus_address_in = 16'h0000; bif.bus_data_in = 8'h00;
    bif.bus_read = 1'b0; bif.bus_write = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_both();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
